// File: rtl/spram_arbiter.sv
// spram_arbiter
//   Shares one internal single-port RAM (WIDTH x DEPTH, async read, sync
//   write) between two requesters, A and B, with round-robin arbitration.
//
//   Optional feature: define SPRAM_ARB_CLEAR_EN to zero the RAM after every
//   reset before requests are accepted.
//
//   Ports
//     clock, reset            rising-edge clock, async active-high reset
//     x_valid / x_ready       request handshake (x = a or b)
//     x_we                    1 = write, 0 = read
//     x_address / x_data      word address / write data
//     x_rvalid / x_Q          one-cycle read-response pulse / registered data
//     busy                    high while requests are not accepted
module spram_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 10,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic             a_we,
  input  logic [AW-1:0]    a_address,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_rvalid,
  output logic [WIDTH-1:0] a_Q,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic             b_we,
  input  logic [AW-1:0]    b_address,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_rvalid,
  output logic [WIDTH-1:0] b_Q,
  output logic             busy
);

  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH] = '{default: '0};

  logic             r_prefer_b;
  logic             w_run;
  logic             w_grant_a;
  logic             w_grant_b;
  logic             w_contend;
  logic             w_xfer;
  logic             w_req_we;
  logic [AW-1:0]    w_req_addr;
  logic [WIDTH-1:0] w_req_data;
  logic             w_in_range;
  logic [WIDTH-1:0] w_rdata;
  logic             w_mem_we;
  logic [AW-1:0]    w_mem_addr;
  logic [WIDTH-1:0] w_mem_wdata;

`ifdef SPRAM_ARB_CLEAR_EN
  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_clr_cnt;
  logic          w_clearing;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_CLEAR;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_CLEAR && r_clr_cnt == LAST_ADDR) w_state_nxt = ST_RUN;
  end

  always_comb begin
    w_clearing = (r_state == ST_CLEAR);
    busy       = w_clearing;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)           r_clr_cnt <= '0;
    else if (w_clearing) r_clr_cnt <= r_clr_cnt + AW'(1);
  end

  assign w_run = ~reset & ~w_clearing;
`else
  assign busy  = 1'b0;
  assign w_run = ~reset;
`endif

  // A wins unless B is also valid and the pointer prefers B; mirror for B,
  // so the two grants are mutually exclusive by construction.
  assign w_grant_a = w_run & a_valid & (~b_valid | ~r_prefer_b);
  assign w_grant_b = w_run & b_valid & (~a_valid |  r_prefer_b);
  assign w_contend = w_run & a_valid & b_valid;
  assign w_xfer    = w_grant_a | w_grant_b;

  assign a_ready = w_grant_a;
  assign b_ready = w_grant_b;

  assign w_req_we   = w_grant_b ? b_we      : a_we;
  assign w_req_addr = w_grant_b ? b_address : a_address;
  assign w_req_data = w_grant_b ? b_data    : a_data;
  assign w_in_range = 32'(w_req_addr) < DEPTH_U;
  assign w_rdata    = w_in_range ? r_mem[w_req_addr] : '0;

  always_comb begin
    w_mem_we    = w_xfer & w_req_we & w_in_range;
    w_mem_addr  = w_req_addr;
    w_mem_wdata = w_req_data;
`ifdef SPRAM_ARB_CLEAR_EN
    if (w_clearing) begin
      w_mem_we    = 1'b1;
      w_mem_addr  = r_clr_cnt;
      w_mem_wdata = '0;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
  end

  // Pointer only moves when both sides competed for the grant.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)          r_prefer_b <= 1'b0;
    else if (w_contend) r_prefer_b <= ~r_prefer_b;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_rvalid <= 1'b0;
      a_Q      <= '0;
      b_rvalid <= 1'b0;
      b_Q      <= '0;
    end else begin
      a_rvalid <= w_grant_a & ~a_we;
      b_rvalid <= w_grant_b & ~b_we;
      if (w_grant_a & ~a_we) a_Q <= w_rdata;
      if (w_grant_b & ~b_we) b_Q <= w_rdata;
    end
  end

endmodule

// File: tb/tb_spram_arbiter.sv
// Scoreboard bench for spram_arbiter (WIDTH=8, DEPTH=10).
module tb_spram_arbiter;

  localparam int WIDTH = 8;
  localparam int DEPTH = 10;
  localparam int AW    = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             a_valid = 1'b0, a_we = 1'b0;
  logic [AW-1:0]    a_address = '0;
  logic [WIDTH-1:0] a_data = '0;
  logic             b_valid = 1'b0, b_we = 1'b0;
  logic [AW-1:0]    b_address = '0;
  logic [WIDTH-1:0] b_data = '0;
  logic             a_ready, a_rvalid, b_ready, b_rvalid, busy;
  logic [WIDTH-1:0] a_Q, b_Q;

  always #5 clock = ~clock;

  spram_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_address(a_address),
    .a_data(a_data), .a_rvalid(a_rvalid), .a_Q(a_Q),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_address(b_address),
    .b_data(b_data), .b_rvalid(b_rvalid), .b_Q(b_Q),
    .busy(busy)
  );

  typedef struct {
    int unsigned cyc;
    logic [7:0]  data;
  } resp_t;

  resp_t       qa[$];
  resp_t       qb[$];
  logic [7:0]  model [DEPTH];
  logic [7:0]  last_a = 8'h00, last_b = 8'h00;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

`ifdef SPRAM_ARB_CLEAR_EN
  localparam logic BUSY_IN_RESET = 1'b1;
`else
  localparam logic BUSY_IN_RESET = 1'b0;
`endif

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops expected read responses whenever the DUT presents one.
  always @(negedge clock) begin
    resp_t e;
    if (reset) begin
      last_a = 8'h00;
      last_b = 8'h00;
    end
    if (a_rvalid) begin
      if (qa.size() == 0) check("a_rvalid_unexpected", a_rvalid, 0);
      else begin
        e = qa.pop_front();
        check("a_rvalid_latency", cyc, e.cyc);
        check("a_Q", a_Q, e.data);
        last_a = e.data;
      end
    end else begin
      check("a_Q_hold", a_Q, last_a);
      if (qa.size() != 0 && qa[0].cyc <= cyc) begin
        check("a_rvalid_missing", a_rvalid, 1);
        void'(qa.pop_front());
      end
    end
    if (b_rvalid) begin
      if (qb.size() == 0) check("b_rvalid_unexpected", b_rvalid, 0);
      else begin
        e = qb.pop_front();
        check("b_rvalid_latency", cyc, e.cyc);
        check("b_Q", b_Q, e.data);
        last_b = e.data;
      end
    end else begin
      check("b_Q_hold", b_Q, last_b);
      if (qb.size() != 0 && qb[0].cyc <= cyc) begin
        check("b_rvalid_missing", b_rvalid, 1);
        void'(qb.pop_front());
      end
    end
  end

  task automatic model_xfer(input logic side_b, input logic we,
                            input logic [3:0] ad, input logic [7:0] d);
    resp_t e;
    if (we) begin
      if (ad < DEPTH) model[ad] = d;
    end else begin
      e.cyc  = cyc + 1;
      e.data = (ad < DEPTH) ? model[ad] : 8'h00;
      if (side_b) qb.push_back(e);
      else        qa.push_back(e);
    end
  endtask

  // One cycle of stimulus; called just after a rising edge.
  // eg = expected {a_ready, b_ready} for this cycle.
  task automatic step(input string nm,
                      input logic av, input logic awe, input logic [3:0] aa, input logic [7:0] ad,
                      input logic bv, input logic bwe, input logic [3:0] ba, input logic [7:0] bd,
                      input logic [1:0] eg);
    a_valid = av; a_we = awe; a_address = aa; a_data = ad;
    b_valid = bv; b_we = bwe; b_address = ba; b_data = bd;
    @(negedge clock);
    check({nm, "_grant"}, {a_ready, b_ready}, eg);
    if (eg[1]) model_xfer(1'b0, awe, aa, ad);
    if (eg[0]) model_xfer(1'b1, bwe, ba, bd);
    @(posedge clock);
    #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic a_only(input string nm, input logic we, input logic [3:0] ad, input logic [7:0] d);
    step(nm, 1'b1, we, ad, d, 1'b0, 1'b0, 4'd0, 8'h00, 2'b10);
  endtask

  task automatic b_only(input string nm, input logic we, input logic [3:0] ad, input logic [7:0] d);
    step(nm, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, we, ad, d, 2'b01);
  endtask

  task automatic idle(input string nm);
    step(nm, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, 2'b00);
  endtask

  // Assert reset with both requesters valid; B tries to write 0xEE to
  // address 1, which must be ignored.
  task automatic do_reset(input string nm);
    a_valid = 1'b1; a_we = 1'b0; a_address = 4'd0;
    b_valid = 1'b1; b_we = 1'b1; b_address = 4'd1; b_data = 8'hEE;
    reset = 1'b1;
    #1;
    check({nm, "_rvalid"}, {a_rvalid, b_rvalid}, 0);
    check({nm, "_Q"}, {a_Q, b_Q}, 0);
    check({nm, "_ready"}, {a_ready, b_ready}, 0);
    check({nm, "_busy"}, busy, BUSY_IN_RESET);
    qa.delete();
    qb.delete();
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
`ifdef SPRAM_ARB_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
`endif
  endtask

`ifdef SPRAM_ARB_CLEAR_EN
  // Checks n sweep cycles with both sides requesting (A tries to write 0xAA).
  task automatic sweep_cycles(input int unsigned n);
    a_valid = 1'b1; a_we = 1'b1; a_address = 4'd2; a_data = 8'hAA;
    b_valid = 1'b1; b_we = 1'b0; b_address = 4'd0;
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clock);
      check("sweep_busy", busy, 1);
      check("sweep_ready", {a_ready, b_ready}, 0);
    end
  endtask

  task automatic full_sweep();
    sweep_cycles(10);
    a_valid = 1'b0;
    b_valid = 1'b0;
    @(posedge clock);
    #1;
    @(negedge clock);
    check("sweep_done_busy", busy, 0);
    @(posedge clock);
    #1;
  endtask
`endif

  task automatic read_all_a(input string nm);
    for (int i = 0; i < DEPTH; i++) a_only(nm, 1'b0, 4'(i), 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    @(posedge clock);
    #1;
    do_reset("rst0");
`ifdef SPRAM_ARB_CLEAR_EN
    full_sweep();
    read_all_a("clr_rd");
`else
    @(negedge clock);
    check("run_busy", busy, 0);
    @(posedge clock);
    #1;
`endif

    // Known contents everywhere.
    for (int i = 0; i < DEPTH; i++) a_only("fill", 1'b1, 4'(i), 8'(16 + i));

    // Solo write then read-after-write.
    a_only("solo_wr", 1'b1, 4'd3, 8'h5A);
    a_only("solo_rd", 1'b0, 4'd3, 8'h00);
    idle("solo_idle");

    // Continuous contention: A writes address 7, B reads address 7.
    step("cont1", 1'b1, 1'b1, 4'd7, 8'h11, 1'b1, 1'b0, 4'd7, 8'h00, 2'b10);
    step("cont2", 1'b1, 1'b1, 4'd7, 8'h22, 1'b1, 1'b0, 4'd7, 8'h00, 2'b01);
    step("cont3", 1'b1, 1'b1, 4'd7, 8'h22, 1'b1, 1'b0, 4'd7, 8'h00, 2'b10);
    step("cont4", 1'b1, 1'b1, 4'd7, 8'h33, 1'b1, 1'b0, 4'd7, 8'h00, 2'b01);
    step("cont5", 1'b1, 1'b1, 4'd7, 8'h33, 1'b1, 1'b0, 4'd7, 8'h00, 2'b10);
    step("cont6", 1'b1, 1'b1, 4'd7, 8'h44, 1'b1, 1'b0, 4'd7, 8'h00, 2'b01);
    idle("cont_idle");

    // Out-of-range address.
    b_only("oor_wr", 1'b1, 4'd12, 8'hFF);
    b_only("oor_rd", 1'b0, 4'd12, 8'h00);
    b_only("oor_rd15", 1'b0, 4'd15, 8'h00);
    read_all_a("oor_chk");

    // Uncontended grants must leave the pointer on A.
    a_only("ptr_a1", 1'b1, 4'd5, 8'h77);
    a_only("ptr_a2", 1'b0, 4'd5, 8'h00);
    a_only("ptr_a3", 1'b0, 4'd7, 8'h00);
    step("ptr_c1", 1'b1, 1'b1, 4'd4, 8'h99, 1'b1, 1'b0, 4'd5, 8'h00, 2'b10);
    step("ptr_c2", 1'b1, 1'b1, 4'd6, 8'h98, 1'b1, 1'b0, 4'd5, 8'h00, 2'b01);
    b_only("ptr_b_rd4", 1'b0, 4'd4, 8'h00);
    idle("ptr_idle");

`ifdef SPRAM_ARB_CLEAR_EN
    // Reset in the middle of a sweep restarts it from address 0.
    do_reset("rst1");
    sweep_cycles(5);
    @(posedge clock);
    #1;
    do_reset("rst_mid");
    full_sweep();
    read_all_a("mid_rd");
    for (int i = 0; i < DEPTH; i++) a_only("refill", 1'b1, 4'(i), 8'(32 + i));
`endif

    // Reset cancels a pending read response; RAM survives reset.
    a_valid = 1'b1; a_we = 1'b0; a_address = 4'd3;
    @(negedge clock);
    check("cancel_grant", {a_ready, b_ready}, 2'b10);
    @(posedge clock);
    #1;
    check("cancel_pre_rvalid", a_rvalid, 1);
    do_reset("rst_cancel");
`ifdef SPRAM_ARB_CLEAR_EN
    full_sweep();
`endif
    a_only("ret_rd3", 1'b0, 4'd3, 8'h00);
    a_only("ret_rd1", 1'b0, 4'd1, 8'h00);
    idle("end_idle1");
    idle("end_idle2");
    check("qa_drained", qa.size(), 0);
    check("qb_drained", qb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
